dmd_video_gen: RTL and testbench

DMD_VIDEO_GEN -- requirements
Module: dmd_video_gen

---
 rtl/dmd_video_gen.sv | 179 +++++++++++++++++
 tb/tb_dmd_video_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmd_video_gen.sv
// Raster timing generator that scales a 128x32 DMD frame buffer into a screen window.
// Frame-buffer bank is latched once per frame at the start of vertical blank.
module dmd_video_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int SCALE    = 6,
  parameter int X_OFF    = 16,
  parameter int Y_OFF    = 144,
  parameter int DOT_GAP  = 1
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic        buf_sel,
  output logic [12:0] rd_addr,
  input  logic [3:0]  rd_data,
  output logic        frame_start,
  output logic        hSync,
  output logic        vSync,
  output logic        DrawArea,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [31:0] X_MAX    = 32'(HT - 1);
  localparam logic [31:0] Y_MAX    = 32'(VT - 1);
  localparam logic [31:0] X_ACT    = 32'(H_ACTIVE);
  localparam logic [31:0] Y_ACT    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_ON    = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_OFF   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_ON    = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_OFF   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] WX_START = 32'(X_OFF);
  localparam logic [31:0] WX_END   = 32'(X_OFF + 128 * SCALE);
  localparam logic [31:0] WY_START = 32'(Y_OFF);
  localparam logic [31:0] WY_END   = 32'(Y_OFF + 32 * SCALE);
  localparam logic [SW-1:0] SUB_MAX = SW'(SCALE - 1);

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic [31:0]   x_w;
  logic [31:0]   y_w;
  logic          x_last;
  logic          y_last;
  logic          win_x;
  logic          win_y;
  logic          win;
  logic          cap;
  logic [SW-1:0] sub_x;
  logic [SW-1:0] sub_y;
  logic [6:0]    col;
  logic [4:0]    row;
  logic          bank_lat;
  logic [12:0]   addr_hold;
  logic          hs1;
  logic          vs1;
  logic          de1;
  logic          win1;
  logic          gap1;
  logic          pix_on;

  assign x_w    = 32'(cnt_x);
  assign y_w    = 32'(cnt_y);
  assign x_last = (x_w == X_MAX);
  assign y_last = (y_w == Y_MAX);
  assign win_x  = (x_w >= WX_START) && (x_w < WX_END);
  assign win_y  = (y_w >= WY_START) && (y_w < WY_END);
  assign win    = win_x && win_y;
  assign cap    = (x_w == 32'd0) && (y_w == Y_ACT);

  assign frame_start = cap;
  // Address is presented in the same cycle as the counters; hold keeps it stable outside the window.
  assign rd_addr = win ? {bank_lat, row, col} : addr_hold;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (x_last) begin
      cnt_x <= '0;
      cnt_y <= y_last ? '0 : cnt_y + 1'b1;
    end else begin
      cnt_x <= cnt_x + 1'b1;
    end
  end

  // Dot counters are held clear outside the window so each line/frame enters it at dot 0.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x <= '0;
      col   <= '0;
    end else if (!win_x) begin
      sub_x <= '0;
      col   <= '0;
    end else if (sub_x == SUB_MAX) begin
      sub_x <= '0;
      col   <= col + 1'b1;
    end else begin
      sub_x <= sub_x + 1'b1;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      sub_y <= '0;
      row   <= '0;
    end else if (x_last) begin
      if (!win_y) begin
        sub_y <= '0;
        row   <= '0;
      end else if (sub_y == SUB_MAX) begin
        sub_y <= '0;
        row   <= row + 1'b1;
      end else begin
        sub_y <= sub_y + 1'b1;
      end
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      bank_lat  <= 1'b0;
      addr_hold <= '0;
    end else begin
      if (cap) bank_lat <= buf_sel;
      addr_hold <= rd_addr;
    end
  end

  // Stage 1 waits alongside the memory read; stage 2 combines it with rd_data.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      de1  <= 1'b0;
      win1 <= 1'b0;
      gap1 <= 1'b0;
    end else begin
      hs1  <= (x_w >= HS_ON) && (x_w < HS_OFF);
      vs1  <= (y_w >= VS_ON) && (y_w < VS_OFF);
      de1  <= (x_w < X_ACT) && (y_w < Y_ACT);
      win1 <= win;
      gap1 <= (DOT_GAP != 0) && ((sub_x == SUB_MAX) || (sub_y == SUB_MAX));
    end
  end

  assign pix_on = win1 && de1 && !gap1;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      hSync    <= 1'b0;
      vSync    <= 1'b0;
      DrawArea <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else begin
      hSync    <= hs1;
      vSync    <= vs1;
      DrawArea <= de1;
      red      <= pix_on ? {rd_data, rd_data} : 8'h00;
      green    <= pix_on ? {1'b0, rd_data, rd_data[3:1]} : 8'h00;
      blue     <= 8'h00;
    end
  end

endmodule

// File: tb/tb_dmd_video_gen.sv
// Bench for dmd_video_gen: a short-frame instance with default horizontal timing and
// dot gaps, plus a small DOT_GAP=0 instance fed a constant full-scale shade.
module tb_dmd_video_gen;

  localparam int HT_A = 928;
  localparam int VT_A = 15;
  localparam int FR_A = HT_A * VT_A;
  localparam int HT_B = 276;
  localparam int VT_B = 72;

  logic        pixclk = 1'b0;
  logic        rst_n;
  logic        buf_sel;
  logic        buf_sel_b;
  logic        mon_en = 1'b0;

  logic [12:0] rd_addr_a, rd_addr_b;
  logic [3:0]  rd_data_a, rd_data_b;
  logic        fs_a, hs_a, vs_a, de_a;
  logic        fs_b, hs_b, vs_b, de_b;
  logic [7:0]  red_a, green_a, blue_a;
  logic [7:0]  red_b, green_b, blue_b;

  int checks = 0;
  int errors = 0;

  always #5 pixclk = ~pixclk;

  assign buf_sel_b = 1'b0;
  assign rd_data_b = 4'hF;
  always @(posedge pixclk) rd_data_a <= rd_addr_a[3:0];

  dmd_video_gen #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(3), .V_BP(2), .Y_OFF(2)) dut_a (
    .pixclk(pixclk), .rst_n(rst_n), .buf_sel(buf_sel), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .frame_start(fs_a), .hSync(hs_a), .vSync(vs_a), .DrawArea(de_a),
    .red(red_a), .green(green_a), .blue(blue_a));

  dmd_video_gen #(.H_ACTIVE(264), .H_FP(4), .H_SYNC(4), .H_BP(4), .V_ACTIVE(68), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .SCALE(2), .X_OFF(4), .Y_OFF(2), .DOT_GAP(0)) dut_b (
    .pixclk(pixclk), .rst_n(rst_n), .buf_sel(buf_sel_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .frame_start(fs_b), .hSync(hs_b), .vSync(vs_b), .DrawArea(de_b),
    .red(red_b), .green(green_b), .blue(blue_b));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Screen-position reference: counters, two-cycle delayed copies, expected bank and address hold.
  int tx = 0, ty = 0, tx1 = 0, ty1 = 0, tx2 = 0, ty2 = 0;
  int bx = 0, by = 0, bx1 = 0, by1 = 0, bx2 = 0, by2 = 0;
  logic v1 = 1'b0, v2 = 1'b0, bv1 = 1'b0, bv2 = 1'b0;
  logic exp_bank = 1'b0;
  logic [12:0] hold_a = '0;

  function automatic logic in_win_a(int x, int y);
    return (x >= 16) && (x < 784) && (y >= 2) && (y < 194);
  endfunction

  function automatic logic [12:0] addr_exp_a(int x, int y, logic b, logic [12:0] h);
    if (in_win_a(x, y)) return {b, 5'(((y - 2) / 6) % 32), 7'(((x - 16) / 6) % 128)};
    return h;
  endfunction

  function automatic logic [15:0] pix_exp_a(int x, int y, logic v);
    logic [3:0] s;
    if (!v || x >= 800 || y >= 8 || !in_win_a(x, y)) return 16'h0000;
    if (((x - 16) % 6 == 5) || ((y - 2) % 6 == 5)) return 16'h0000;
    s = 4'(((x - 16) / 6) % 16);
    return {s, s, 1'b0, s, s[3:1]};
  endfunction

  function automatic logic in_win_b(int x, int y);
    return (x >= 4) && (x < 260) && (y >= 2) && (y < 66);
  endfunction

  always @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= 0; ty <= 0; tx1 <= 0; ty1 <= 0; tx2 <= 0; ty2 <= 0; v1 <= 1'b0; v2 <= 1'b0;
      bx <= 0; by <= 0; bx1 <= 0; by1 <= 0; bx2 <= 0; by2 <= 0; bv1 <= 1'b0; bv2 <= 1'b0;
      exp_bank <= 1'b0; hold_a <= '0;
    end else begin
      if (tx == HT_A - 1) begin
        tx <= 0;
        ty <= (ty == VT_A - 1) ? 0 : ty + 1;
      end else tx <= tx + 1;
      if (bx == HT_B - 1) begin
        bx <= 0;
        by <= (by == VT_B - 1) ? 0 : by + 1;
      end else bx <= bx + 1;
      tx1 <= tx; ty1 <= ty; v1 <= 1'b1; tx2 <= tx1; ty2 <= ty1; v2 <= v1;
      bx1 <= bx; by1 <= by; bv1 <= 1'b1; bx2 <= bx1; by2 <= by1; bv2 <= bv1;
      if (tx == 0 && ty == 8) exp_bank <= buf_sel;
      hold_a <= addr_exp_a(tx, ty, exp_bank, hold_a);
    end
  end

  // Per-cycle tallies against the reference, plus frame statistics over two whole frames.
  int err_sync_a = 0, err_pix_a = 0, err_addr_a = 0, err_fs_a = 0, err_b = 0;
  int since_hs = 0, hs_seen = 0, hs_gap_err = 0, since_fs = 0, fs_seen = 0, fs_gap_err = 0;
  int de_cnt = 0, vs_cnt = 0, hs_hi = 0, hs_rise = 0, fsb_seen = 0, ff_cnt_b = 0;
  logic hs_prev_a = 1'b0;
  logic meas_a, meas_b;

  assign meas_a = fs_a ? (fs_seen < 2) : (fs_seen >= 1 && fs_seen <= 2);
  assign meas_b = fs_b ? (fsb_seen < 1) : (fsb_seen == 1);

  always @(negedge pixclk) begin
    if (mon_en) begin
      if ({hs_a, vs_a, de_a} !== {v2 && tx2 >= 840 && tx2 < 888, v2 && ty2 >= 10 && ty2 < 13,
                                  v2 && tx2 < 800 && ty2 < 8})
        err_sync_a <= err_sync_a + 1;
      if ({red_a, green_a, blue_a} !== {pix_exp_a(tx2, ty2, v2), 8'h00}) err_pix_a <= err_pix_a + 1;
      if (rd_addr_a !== addr_exp_a(tx, ty, exp_bank, hold_a)) err_addr_a <= err_addr_a + 1;
      if (fs_a !== (tx == 0 && ty == 8)) err_fs_a <= err_fs_a + 1;

      hs_prev_a <= hs_a;
      if (hs_a && !hs_prev_a) begin
        since_hs <= 0;
        hs_seen  <= hs_seen + 1;
        if (hs_seen > 0 && since_hs != HT_A - 1) hs_gap_err <= hs_gap_err + 1;
      end else since_hs <= since_hs + 1;
      if (fs_a) begin
        since_fs <= 0;
        fs_seen  <= fs_seen + 1;
        if (fs_seen > 0 && since_fs != FR_A - 1) fs_gap_err <= fs_gap_err + 1;
      end else since_fs <= since_fs + 1;
      if (meas_a) begin
        de_cnt <= de_cnt + int'(de_a);
        vs_cnt <= vs_cnt + int'(vs_a);
        hs_hi  <= hs_hi + int'(hs_a);
        if (hs_a && !hs_prev_a) hs_rise <= hs_rise + 1;
      end

      if ({red_b, green_b, blue_b} !== ((bv2 && in_win_b(bx2, by2)) ? 24'hFF7F00 : 24'h000000) ||
          {hs_b, vs_b, de_b} !== {bv2 && bx2 >= 268 && bx2 < 272, bv2 && by2 >= 69 && by2 < 71,
                                  bv2 && bx2 < 264 && by2 < 68} ||
          fs_b !== (bx == 0 && by == 68) ||
          (in_win_b(bx, by) && rd_addr_b !== {1'b0, 5'((by - 2) / 2), 7'((bx - 4) / 2)}))
        err_b <= err_b + 1;
      if (fs_b) fsb_seen <= fsb_seen + 1;
      if (meas_b && red_b == 8'hFF) ff_cnt_b <= ff_cnt_b + 1;
    end
  end

  task automatic wait_xy(input string tag, input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge pixclk);
      n++;
    end while (!(tx == x && ty == y) && n < 20000);
    check_val(tag, {16'(tx), 16'(ty)}, {16'(x), 16'(y)});
  endtask

  logic [7:0] red_tab [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h00};

  initial begin
    int n;
    rst_n   = 1'b1;
    buf_sel = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge pixclk);
    check_val("reset_outs", {fs_a, hs_a, vs_a, de_a, red_a, green_a, blue_a}, 32'h0);
    check_val("reset_addr", 32'(rd_addr_a), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge pixclk);
    check_val("de_cycle1", 32'(de_a), 32'h0);
    @(negedge pixclk);
    check_val("de_cycle2", {de_a, red_a}, {1'b1, 8'h00});

    wait_xy("wait_c16", 16, 2);
    check_val("addr_c16", 32'(rd_addr_a), 32'd0);
    repeat (2) @(negedge pixclk);
    for (int k = 0; k < 12; k++) begin
      check_val($sformatf("red_c%0d", 16 + k), 32'(red_a), 32'(red_tab[k]));
      if (k == 6) check_val("green_c22", 32'(green_a), 32'h08);
      @(negedge pixclk);
    end
    wait_xy("wait_c778", 778, 2);
    check_val("addr_c778", 32'(rd_addr_a), 32'd127);
    repeat (6) @(negedge pixclk);
    check_val("addr_hold", 32'(rd_addr_a), 32'd127);

    wait_xy("wait_fs1", 0, 8);
    check_val("fs_pulse", 32'(fs_a), 32'd1);
    @(negedge pixclk);
    check_val("fs_end", 32'(fs_a), 32'd0);
    wait_xy("wait_swap", 400, 3);
    buf_sel = 1'b1;
    wait_xy("wait_mid", 100, 5);
    check_val("bank_hold", 32'(rd_addr_a), 32'd14);
    wait_xy("wait_fs2", 0, 8);
    check_val("fs_pulse2", 32'(fs_a), 32'd1);
    wait_xy("wait_nf", 16, 2);
    check_val("bank_new", 32'(rd_addr_a), 32'h1000);
    wait_xy("wait_swap2", 200, 3);
    buf_sel = 1'b0;
    wait_xy("wait_c778b", 778, 6);
    check_val("bank_keep", 32'(rd_addr_a), 32'h107F);
    wait_xy("wait_fs3", 0, 8);

    wait_xy("wait_rst", 500, 5);
    check_val("pre_rst", {de_a, 19'h0, rd_addr_a[11:0]}, {1'b1, 19'h0, 12'd80});
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_val("rst_now_outs", {fs_a, hs_a, vs_a, de_a, red_a, green_a, blue_a}, 32'h0);
    check_val("rst_now_addr", 32'(rd_addr_a), 32'h0);
    repeat (3) @(negedge pixclk);
    check_val("rst_held", {fs_a, hs_a, vs_a, de_a, red_a, green_a, blue_a, 4'h0}, {19'h0, rd_addr_a});
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge pixclk);
      n++;
    end while (!hs_a && n < 2000);
    check_val("hs_after_rst", 32'(n), 32'd842);

    check_val("sync_model_a", 32'(err_sync_a), 32'd0);
    check_val("pix_model_a", 32'(err_pix_a), 32'd0);
    check_val("addr_model_a", 32'(err_addr_a), 32'd0);
    check_val("fs_model_a", 32'(err_fs_a), 32'd0);
    check_val("fs_count", 32'(fs_seen), 32'd3);
    check_val("fs_period", 32'(fs_gap_err), 32'd0);
    check_val("hs_period", 32'(hs_gap_err), 32'd0);
    check_val("hs_rises", 32'(hs_rise), 32'd30);
    check_val("hs_width", 32'(hs_hi), 32'd1440);
    check_val("vs_width", 32'(vs_cnt), 32'd5568);
    check_val("de_count", 32'(de_cnt), 32'd12800);
    check_val("model_b", 32'(err_b), 32'd0);
    check_val("win_pix_b", 32'(ff_cnt_b), 32'd16384);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
